// File: rtl/keypad_pkg.sv
// Shared types, constants and small bit helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } kp_state_t;

  localparam int KP_W = 4;
  localparam logic [KP_W-1:0] ROW_FIRST = 4'b0001;

  function automatic logic is_onehot(input logic [KP_W-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  function automatic logic [KP_W-1:0] next_row(input logic [KP_W-1:0] r);
    return {r[KP_W-2:0], r[KP_W-1]};
  endfunction

  function automatic logic [1:0] onehot_index(input logic [KP_W-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_W; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Maps a one-hot {row, col} pair to a 4-bit key code (decimal or hex layout).
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int BASE = 10
) (
  input  logic [KP_W-1:0] row,
  input  logic [KP_W-1:0] col,
  output logic [3:0]      code,
  output logic            valid
);

  // Decimal layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D  (*=14, #=15)
  localparam logic [3:0] DEC_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  logic [3:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    idx   = {onehot_index(row), onehot_index(col)};
    code  = '0;
    valid = is_onehot(row) && is_onehot(col) && (BASE == 10 || BASE == 16);
    if (BASE == 16) code = idx;
    else            code = DEC_MAP[idx];
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning, debouncing 4x4 keypad front end: one key_valid strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int BASE         = 10,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [KP_W-1:0] col_in,
  output logic [KP_W-1:0] row_out,
  output logic [3:0]      key_value,
  output logic            key_valid,
  output logic            key_held
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

  kp_state_t          state;
  logic [KP_W-1:0]    col_m, col_s;
  logic [KP_W-1:0]    row_lat, col_lat;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DEB_W-1:0]   deb_cnt;
  logic [3:0]         dec_code;
  logic               dec_valid;

  keypad_decoder #(.BASE(BASE)) u_dec (
    .row   (row_lat),
    .col   (col_lat),
    .code  (dec_code),
    .valid (dec_valid)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= '0;
      col_s <= '0;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_out   <= ROW_FIRST;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      row_lat   <= '0;
      col_lat   <= '0;
      key_value <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else if (!en) begin
      state     <= SCAN;
      row_out   <= '0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // An all-zero row only occurs right after en returns: restart at row 0.
          if (row_out == '0) begin
            row_out   <= ROW_FIRST;
            dwell_cnt <= '0;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (is_onehot(col_s)) begin
              row_lat <= row_out;
              col_lat <= col_s;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_out <= next_row(row_out);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end

        DEBOUNCE: begin
          if (col_s != col_lat) begin
            deb_cnt <= '0;
            row_out <= next_row(row_out);
            state   <= SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            if (dec_valid) begin
              key_value <= dec_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= PRESSED;
            end else begin
              row_out <= next_row(row_out);
              state   <= SCAN;
            end
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          if (col_s != '0) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            key_held <= 1'b0;
            row_out  <= next_row(row_out);
            state    <= SCAN;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: decimal and hex instances share one keypad model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic       press_on = 1'b0;
  logic [3:0] press_row = 4'b0001;
  logic [3:0] press_col = 4'b0001;

  logic [3:0] col10, row10, value10;
  logic [3:0] col16, row16, value16;
  logic       valid10, held10, valid16, held16;
  logic       prev_valid10 = 1'b0, prev_valid16 = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp10_q[$];
  logic [3:0] exp16_q[$];

  always #5 clk = ~clk;

  assign col10 = (press_on && row10 == press_row) ? press_col : 4'b0000;
  assign col16 = (press_on && row16 == press_row) ? press_col : 4'b0000;

  keypad_scanner #(.BASE(10), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en), .col_in(col10), .row_out(row10),
    .key_value(value10), .key_valid(valid10), .key_held(held10)
  );

  keypad_scanner #(.BASE(16), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .col_in(col16), .row_out(row16),
    .key_value(value16), .key_valid(valid16), .key_held(held16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe pops one expected code per instance.
  always @(negedge clk) begin
    if (valid10) begin
      check("strobe_width10", 32'(prev_valid10), 0);
      check("held_at_strobe10", 32'(held10), 1);
      if (exp10_q.size() == 0) check("unexpected_strobe10", 32'(valid10), 0);
      else                     check("key_value10", 32'(value10), 32'(exp10_q.pop_front()));
    end
    if (valid16) begin
      check("strobe_width16", 32'(prev_valid16), 0);
      if (exp16_q.size() == 0) check("unexpected_strobe16", 32'(valid16), 0);
      else                     check("key_value16", 32'(value16), 32'(exp16_q.pop_front()));
    end
    prev_valid10 <= valid10;
    prev_valid16 <= valid16;
  end

  task automatic expect_key(input logic [3:0] v10, input logic [3:0] v16);
    exp10_q.push_back(v10);
    exp16_q.push_back(v16);
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    press_row = r;
    press_col = c;
    press_on  = 1'b1;
  endtask

  task automatic wait_held(input logic level, input int budget, input string name);
    int n = 0;
    while (held10 !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(held10), 32'(level));
  endtask

  // Releases the key and returns the posedges until key_held falls (bounded).
  task automatic release_and_measure(output int n);
    @(negedge clk);
    press_on = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (held10 && n < 60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] seen;

    // 1. Reset values, then an idle scan of all rows with 4-cycle dwell.
    #1 rst_n = 1'b0;
    #1;
    check("reset_row", 32'(row10), 32'(4'b0001));
    check("reset_value", 32'(value10), 0);
    check("reset_valid", 32'(valid10), 0);
    check("reset_held", 32'(held10), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int p = 1; p <= 20; p++) begin
      @(posedge clk);
      #1;
      check("idle_scan_row", 32'(row10), 32'(4'b0001 << ((p / 4) % 4)));
    end
    check("idle_valid", 32'(valid10), 0);
    check("idle_held", 32'(held10), 0);

    // 2. Key 5 held 200 cycles; held drops 10 cycles after release.
    expect_key(4'd5, 4'd5);
    press(4'b0010, 4'b0010);
    repeat (200) @(posedge clk);
    #1 check("held_before_release_k5", 32'(held10), 1);
    release_and_measure(n);
    check("release_latency_k5", 32'(n), 10);

    // 3. Bottom-right key: D (13) in decimal, F (15) in hex; value kept after release.
    repeat (10) @(posedge clk);
    expect_key(4'd13, 4'd15);
    press(4'b1000, 4'b1000);
    repeat (500) @(posedge clk);
    #1 check("held_before_release_kD", 32'(held10), 1);
    release_and_measure(n);
    check("release_latency_kD", 32'(n), 10);
    check("value_kept10", 32'(value10), 13);
    check("value_kept16", 32'(value16), 15);

    // 4. Bouncing contact: no strobe while toggling, exactly one once stable.
    repeat (10) @(posedge clk);
    press(4'b0100, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      press_on = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    check("bounce_no_early_strobe", 32'(exp10_q.size()), 0);
    expect_key(4'd7, 4'd8);
    press_on = 1'b1;
    repeat (300) @(posedge clk);
    release_and_measure(n);
    check("release_latency_bounce", 32'(n), 10);

    // 5. Two keys in one row: no strobe, scan keeps visiting every row.
    repeat (10) @(posedge clk);
    press(4'b0100, 4'b0011);
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen = seen | row10;
    end
    check("two_keys_rows_seen", 32'(seen), 32'(4'b1111));
    check("two_keys_no_held", 32'(held10), 0);
    @(negedge clk) press_on = 1'b0;
    repeat (10) @(posedge clk);

    // 6a. en dropped while PRESSED; resume restarts at row 0001 with a full dwell.
    expect_key(4'd3, 4'd2);
    press(4'b0001, 4'b0100);
    wait_held(1'b1, 200, "held_rise_k3");
    @(negedge clk) en = 1'b0;
    @(posedge clk);
    #1;
    check("en_off_row", 32'(row10), 0);
    check("en_off_held", 32'(held10), 0);
    check("en_off_valid", 32'(valid10), 0);
    @(negedge clk) press_on = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1 check("resume_row", 32'(row10), 32'(4'b0001));
    repeat (3) @(posedge clk);
    #1 check("resume_dwell_hold", 32'(row10), 32'(4'b0001));
    @(posedge clk);
    #1 check("resume_dwell_advance", 32'(row10), 32'(4'b0010));

    // 6b. Asynchronous reset during DEBOUNCE; no strobe afterwards.
    repeat (10) @(posedge clk);
    press(4'b0010, 4'b0010);
    n = 0;
    while (row10 == 4'b0010 && n < 100) begin @(negedge clk); n++; end
    while (row10 != 4'b0010 && n < 100) begin @(negedge clk); n++; end
    check("found_row_0010", 32'(row10), 32'(4'b0010));
    repeat (7) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_reset_row", 32'(row10), 32'(4'b0001));
    check("mid_reset_value10", 32'(value10), 0);
    check("mid_reset_value16", 32'(value16), 0);
    check("mid_reset_valid", 32'(valid10), 0);
    check("mid_reset_held", 32'(held10), 0);
    press_on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1 check("after_reset_held", 32'(held10), 0);

    check("pending10", 32'(exp10_q.size()), 0);
    check("pending16", 32'(exp16_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
